// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the MIPS boot-time program loader.
package mips_loader_pkg;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    CHK,
    DONE,
    ERR
  } loader_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/loader_word_asm.sv
// Little-endian 4-byte word assembler: collects bytes into lanes 0..3 and
// presents the finished word with a one-cycle word_valid pulse.
module loader_word_asm
  import mips_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_vld,
  input  logic [7:0]  in_byte,
  output logic [1:0]  lane,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] low_p0;

  // stage 0: lanes 0..2 held until the top byte arrives
  always_ff @(posedge clk) begin
    if (in_vld) begin
      case (lane)
        2'd0:    low_p0[7:0]   <= in_byte;
        2'd1:    low_p0[15:8]  <= in_byte;
        default: low_p0[23:16] <= in_byte;
      endcase
    end
  end

  // stage 1: completed word and its strobe, registered
  always_ff @(posedge clk) begin
    if (rst) begin
      lane       <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        lane <= '0;
      end else if (in_vld) begin
        if (lane == 2'(BYTES_PER_WORD - 1)) begin
          word       <= {in_byte, low_p0};
          word_valid <= 1'b1;
          lane       <= '0;
        end else begin
          lane <= lane + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/mips_prog_loader.sv
// Boot loader: parses a count/payload/checksum byte stream, writes words into
// instruction memory and releases the core only after a verified image.
module mips_prog_loader
  import mips_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  loader_state_t state;
  logic [15:0]   count;
  logic [7:0]    acc;
  logic [15:0]   hdr_n;
  logic [1:0]    lane;
  logic          accept;
  logic          reload_ok;
  logic          last_lane;

  assign byte_ready = ~rst & (state inside {HDR0, HDR1, DATA, CHK});
  assign accept     = byte_valid & byte_ready;
  assign reload_ok  = reload & (state inside {DONE, ERR});
  assign last_lane  = (lane == 2'(BYTES_PER_WORD - 1));
  assign hdr_n      = {byte_data, count[7:0]};

  loader_word_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (reload_ok),
    .in_vld     (accept && (state == DATA)),
    .in_byte    (byte_data),
    .lane       (lane),
    .word_valid (imem_we),
    .word       (imem_wdata)
  );

  // stage 0 -> 1: parse FSM; the write address is registered alongside the word
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HDR0;
      count        <= '0;
      acc          <= '0;
      words_loaded <= '0;
      imem_addr    <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_run      <= 1'b0;
    end else begin
      case (state)
        HDR0: if (accept) begin
          count[7:0] <= byte_data;
          acc        <= acc ^ byte_data;
          state      <= HDR1;
        end
        HDR1: if (accept) begin
          count[15:8] <= byte_data;
          acc         <= acc ^ byte_data;
          if (32'(hdr_n) > MAX_WORDS) begin
            state <= ERR;
            error <= 1'b1;
          end else if (hdr_n == 16'd0) begin
            state <= CHK;
          end else begin
            state <= DATA;
          end
        end
        DATA: if (accept) begin
          acc <= acc ^ byte_data;
          if (last_lane) begin
            imem_addr    <= ADDR_W'(BASE_ADDR + int'(words_loaded));
            words_loaded <= words_loaded + 1'b1;
            if (32'(words_loaded) + 32'd1 == 32'(count)) state <= CHK;
          end
        end
        CHK: if (accept) begin
          if (byte_data == acc) begin
            state   <= DONE;
            done    <= 1'b1;
            cpu_run <= 1'b1;
          end else begin
            state <= ERR;
            error <= 1'b1;
          end
        end
        DONE, ERR: if (reload_ok) begin
          state        <= HDR0;
          acc          <= '0;
          words_loaded <= '0;
          done         <= 1'b0;
          error        <= 1'b0;
          cpu_run      <= 1'b0;
        end
        default: state <= HDR0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Self-checking bench: position-based image model compared every cycle, plus
// directed scenarios with literal expectations and randomized images.
module tb_mips_prog_loader;
  import mips_loader_pkg::*;

  localparam int ADDR_W    = 8;
  localparam int BASE_ADDR = 0;
  localparam int MAX_WORDS = 256;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              rst;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_run;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  mips_prog_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .MAX_WORDS(MAX_WORDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .reload       (reload),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_run      (cpu_run),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: status 0 = loading, 1 = accepted, 2 = rejected; position counts bytes in image.
  int          m_status = 0;
  int          m_pos    = 0;
  int          m_n      = 0;
  int          m_wl     = 0;
  logic [7:0]  m_xor    = '0;
  logic [15:0] m_hdr    = '0;
  logic [31:0] m_word   = '0;
  logic        m_we     = 1'b0;
  logic [7:0]  m_addr   = '0;
  logic [31:0] m_wdata  = '0;

  always @(posedge clk) begin
    int p;
    if (rst) begin
      m_status = 0; m_pos = 0; m_n = 0; m_wl = 0; m_xor = '0;
      m_we = 1'b0; m_addr = '0; m_wdata = '0;
    end else begin
      m_we = 1'b0;
      if (m_status != 0) begin
        if (reload) begin
          m_status = 0; m_pos = 0; m_xor = '0; m_wl = 0;
        end
      end else if (byte_valid) begin
        if (m_pos < HDR_BYTES) begin
          m_hdr[8*m_pos +: 8] = byte_data;
          m_xor ^= byte_data;
          m_pos++;
          if (m_pos == HDR_BYTES) begin
            m_n = int'(m_hdr);
            if (m_n > MAX_WORDS) m_status = 2;
          end
        end else if (m_pos - HDR_BYTES < 4 * m_n) begin
          p = m_pos - HDR_BYTES;
          m_word[8*(p%4) +: 8] = byte_data;
          m_xor ^= byte_data;
          if (p % 4 == 3) begin
            m_we    = 1'b1;
            m_addr  = 8'(BASE_ADDR + p / 4);
            m_wdata = m_word;
            m_wl++;
          end
          m_pos++;
        end else begin
          m_status = (byte_data == m_xor) ? 1 : 2;
        end
      end
    end
  end

  logic [39:0] wq[$];

  always @(negedge clk) begin
    if (armed) begin
      chk("byte_ready",   byte_ready,   (m_status == 0) && !rst);
      chk("imem_we",      imem_we,      m_we);
      chk("imem_addr",    imem_addr,    m_addr);
      chk("imem_wdata",   imem_wdata,   m_wdata);
      chk("done",         done,         m_status == 1);
      chk("cpu_run",      cpu_run,      m_status == 1);
      chk("error",        error,        m_status == 2);
      chk("words_loaded", words_loaded, 9'(m_wl));
      if (imem_we === 1'b1) wq.push_back({imem_addr, imem_wdata});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_img(input bq_t img, input int maxgap, input bit rnd_reload);
    foreach (img[i]) begin
      if (m_status != 0) break;
      repeat ($urandom_range(0, maxgap)) step();
      byte_valid = 1'b1;
      byte_data  = img[i];
      reload     = rnd_reload && ($urandom_range(0, 4) == 0);
      step();
      byte_valid = 1'b0;
      reload     = 1'b0;
    end
  endtask

  task automatic wait_end();
    int k = 0;
    while (!(done === 1'b1 || error === 1'b1) && k < 20) begin
      step();
      k++;
    end
    checks++;
    if (k >= 20) begin
      errors++;
      $display("FAIL end_wait actual=timeout required=done_or_error");
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    byte_valid = $urandom_range(0, 1) == 1;
    step();
    reload = 1'b0;
    byte_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=stuck required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    bq_t nominal, bad, img, part;
    int  n, cut;
    logic [7:0] cs;

    nominal = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2F};
    bad     = nominal;
    bad[10] = 8'h2E;

    rst = 1'b1; byte_valid = 1'b0; byte_data = '0; reload = 1'b0;
    step();
    armed = 1'b1;
    chk("reset_ready", byte_ready, 1'b0);
    chk("reset_words", words_loaded, 0);
    step();
    rst = 1'b0;
    step();

    // nominal image
    wq.delete();
    send_img(nominal, 0, 1'b0);
    chk("nom_done", done, 1'b1);
    chk("nom_run", cpu_run, 1'b1);
    chk("nom_words", words_loaded, 2);
    chk("nom_nwrites", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("nom_w0", wq[0], {8'h00, 32'h2008_0005});
      chk("nom_w1", wq[1], {8'h01, 32'h0000_0000});
    end

    // reload from DONE then a one-word image
    reload = 1'b1;
    step();
    reload = 1'b0;
    chk("rl_run", cpu_run, 1'b0);
    chk("rl_done", done, 1'b0);
    chk("rl_words", words_loaded, 0);
    wq.delete();
    send_img('{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23}, 0, 1'b0);
    chk("rl_nwrites", wq.size(), 1);
    if (wq.size() == 1) chk("rl_w0", wq[0], {8'h00, 32'hDEAD_BEEF});
    chk("rl_done2", done, 1'b1);
    pulse_reload();

    // bad checksum
    wq.delete();
    send_img(bad, 0, 1'b0);
    chk("bad_nwrites", wq.size(), 2);
    chk("bad_error", error, 1'b1);
    chk("bad_run", cpu_run, 1'b0);
    chk("bad_done", done, 1'b0);
    step();
    chk("bad_ready", byte_ready, 1'b0);
    pulse_reload();

    // empty image
    wq.delete();
    send_img('{8'h00, 8'h00, 8'h00}, 0, 1'b0);
    chk("empty_nwrites", wq.size(), 0);
    chk("empty_done", done, 1'b1);
    chk("empty_run", cpu_run, 1'b1);
    pulse_reload();

    // oversize header N=257
    wq.delete();
    send_img('{8'h01, 8'h01}, 0, 1'b0);
    chk("over_error", error, 1'b1);
    step();
    chk("over_nwrites", wq.size(), 0);
    pulse_reload();

    // gapped valid, reset after six bytes, then a fresh nominal load
    for (int i = 0; i < 6; i++) begin
      byte_valid = 1'b1; byte_data = nominal[i];
      step();
      byte_valid = 1'b0;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_words", words_loaded, 0);
    chk("mid_addr", imem_addr, 0);
    chk("mid_wdata", imem_wdata, 0);
    chk("mid_we", imem_we, 1'b0);
    wq.delete();
    send_img(nominal, 1, 1'b0);
    chk("mid_done", done, 1'b1);
    chk("mid_nwrites", wq.size(), 2);
    pulse_reload();

    // randomized images against the model
    for (int it = 0; it < 60; it++) begin
      n = ($urandom_range(0, 9) == 0) ? 257 + $urandom_range(0, 3) : $urandom_range(0, 5);
      img = {};
      img.push_back(8'(n));
      img.push_back(8'(n >> 8));
      if (n <= MAX_WORDS) for (int b = 0; b < 4 * n; b++) img.push_back(8'($urandom_range(0, 255)));
      cs = '0;
      foreach (img[j]) cs ^= img[j];
      if ($urandom_range(0, 3) == 0) cs ^= 8'($urandom_range(1, 255));
      img.push_back(cs);
      cut = ($urandom_range(0, 6) == 0) ? $urandom_range(1, img.size() - 1) : img.size();
      part = img[0:cut-1];
      send_img(part, 2, 1'b1);
      if (cut < img.size() && m_status == 0) begin
        rst = 1'b1;
        reload = $urandom_range(0, 1) == 1;
        step();
        rst = 1'b0;
        reload = 1'b0;
      end else begin
        wait_end();
        step();
        pulse_reload();
      end
    end

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
